// File: rtl/dma_pkg.sv
// Shared DMA package: requester-count default and the DRAM arbiter FSM state type.
// Imported by dram_arbiter and the DMA controller.
package dma_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } arbStateE;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   reqVec      : per-requester request bits
//   lastGrant   : index of the most recently completed grant (lowest priority)
//   grantOneHot : one-hot winner, all zero when nothing requests
//   grantIdx    : index of the winner, 0 when nothing requests
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [IDX_W-1:0]   lastGrant,
    output logic [NUM_REQ-1:0] grantOneHot,
    output logic [IDX_W-1:0]   grantIdx
);

    logic        found;
    int unsigned cand;

    // Scan from lastGrant+1 around to lastGrant itself; the first hit wins.
    always_comb begin
        grantOneHot = '0;
        grantIdx    = '0;
        found       = 1'b0;
        cand        = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(lastGrant) + i) % NUM_REQ;
            if (!found && reqVec[cand[IDX_W-1:0]]) begin
                found                         = 1'b1;
                grantIdx                      = cand[IDX_W-1:0];
                grantOneHot[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port between NUM_REQ DMA requesters.
//   clk, reset             : clock, asynchronous active-low reset
//   reqReadEnable/WriteEnable, reqAddress, reqWriteData : requester side inputs
//   reqValid, reqReadData  : one-hot completion pulse and shared read-return data
//   dramAddress, dramWriteData, dramReadEnable, dramWriteEnable : registered DRAM request
//   dramReadData, dramValid : DRAM completion
//   grantId                : index of current/last grant
module dram_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               reqReadEnable,
    input  logic [NUM_REQ-1:0]               reqWriteEnable,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   reqAddress,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   reqWriteData,
    output logic [NUM_REQ-1:0]               reqValid,
    output logic [ADDR_W-1:0]                reqReadData,
    output logic [ADDR_W-1:0]                dramAddress,
    output logic [ADDR_W-1:0]                dramWriteData,
    output logic                             dramReadEnable,
    output logic                             dramWriteEnable,
    input  logic [ADDR_W-1:0]                dramReadData,
    input  logic                             dramValid,
    output logic [$clog2(NUM_REQ)-1:0]       grantId
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arbStateE             stateQ, stateD;
    logic [IDX_W-1:0]     lastGrantQ, lastGrantD;
    logic [IDX_W-1:0]     grantIdQ, grantIdD;
    logic [ADDR_W-1:0]    dramAddressQ, dramAddressD;
    logic [ADDR_W-1:0]    dramWriteDataQ, dramWriteDataD;
    logic                 readEnQ, readEnD;
    logic                 writeEnQ, writeEnD;
    logic [ADDR_W-1:0]    readDataQ, readDataD;
    logic [NUM_REQ-1:0]   reqValidQ, reqValidD;

    logic [NUM_REQ-1:0]   pickOneHot;
    logic [IDX_W-1:0]     pickIdx;
    logic                 writeSel;
    logic                 readSel;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPicker (
        .reqVec      (reqReadEnable | reqWriteEnable),
        .lastGrant   (lastGrantQ),
        .grantOneHot (pickOneHot),
        .grantIdx    (pickIdx)
    );

    // Write wins when a requester raises both enables.
    assign writeSel = |(pickOneHot & reqWriteEnable);
    assign readSel  = (|(pickOneHot & reqReadEnable)) & ~writeSel;

    always_comb begin
        stateD         = stateQ;
        lastGrantD     = lastGrantQ;
        grantIdD       = grantIdQ;
        dramAddressD   = dramAddressQ;
        dramWriteDataD = dramWriteDataQ;
        readEnD        = readEnQ;
        writeEnD       = writeEnQ;
        readDataD      = readDataQ;
        reqValidD      = '0;
        unique case (stateQ)
            StIdle: begin
                readEnD  = 1'b0;
                writeEnD = 1'b0;
                if (|pickOneHot) begin
                    grantIdD       = pickIdx;
                    dramAddressD   = reqAddress[pickIdx];
                    dramWriteDataD = reqWriteData[pickIdx];
                    readEnD        = readSel;
                    writeEnD       = writeSel;
                    stateD         = StBusy;
                end
            end
            StBusy: begin
                // Requester inputs are not looked at here; the request is frozen.
                if (dramValid) begin
                    readDataD           = dramReadData;
                    readEnD             = 1'b0;
                    writeEnD            = 1'b0;
                    reqValidD[grantIdQ] = 1'b1;
                    lastGrantD          = grantIdQ;
                    stateD              = StDone;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ         <= StIdle;
            lastGrantQ     <= IDX_W'(NUM_REQ - 1);
            grantIdQ       <= '0;
            dramAddressQ   <= '0;
            dramWriteDataQ <= '0;
            readEnQ        <= 1'b0;
            writeEnQ       <= 1'b0;
            readDataQ      <= '0;
            reqValidQ      <= '0;
        end else begin
            stateQ         <= stateD;
            lastGrantQ     <= lastGrantD;
            grantIdQ       <= grantIdD;
            dramAddressQ   <= dramAddressD;
            dramWriteDataQ <= dramWriteDataD;
            readEnQ        <= readEnD;
            writeEnQ       <= writeEnD;
            readDataQ      <= readDataD;
            reqValidQ      <= reqValidD;
        end
    end

    assign reqValid        = reqValidQ;
    assign reqReadData     = readDataQ;
    assign dramAddress     = dramAddressQ;
    assign dramWriteData   = dramWriteDataQ;
    assign dramReadEnable  = readEnQ;
    assign dramWriteEnable = writeEnQ;
    assign grantId         = grantIdQ;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_dram_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        rdEn, wrEn;
    logic [N-1:0][W-1:0] addr, wdata;
    logic [N-1:0]        reqValid;
    logic [W-1:0]        reqReadData, dramAddress, dramWriteData, dramReadData;
    logic                dramReadEnable, dramWriteEnable, dramValid;
    logic [1:0]          grantId;

    int errors = 0;
    int checks = 0;
    int mLast;

    dram_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reqReadEnable   (rdEn),
        .reqWriteEnable  (wrEn),
        .reqAddress      (addr),
        .reqWriteData    (wdata),
        .reqValid        (reqValid),
        .reqReadData     (reqReadData),
        .dramAddress     (dramAddress),
        .dramWriteData   (dramWriteData),
        .dramReadEnable  (dramReadEnable),
        .dramWriteEnable (dramWriteEnable),
        .dramReadData    (dramReadData),
        .dramValid       (dramValid),
        .grantId         (grantId)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Rule: first pending requester scanning from last+1 around the ring.
    function automatic int pickNext(input logic [N-1:0] pend, input int last);
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (last + i) % N;
            if (pend[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic checkAllZero(input string tag);
        chk({tag, "_enables"}, 64'({dramReadEnable, dramWriteEnable}), 64'(0));
        chk({tag, "_dramAddress"}, 64'(dramAddress), 64'(0));
        chk({tag, "_dramWriteData"}, 64'(dramWriteData), 64'(0));
        chk({tag, "_reqReadData"}, 64'(reqReadData), 64'(0));
        chk({tag, "_reqValid"}, 64'(reqValid), 64'(0));
        chk({tag, "_grantId"}, 64'(grantId), 64'(0));
    endtask

    // Reset at a negedge, release at a later negedge; model's last grant goes to N-1.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        rdEn  = '0;
        wrEn  = '0;
        dramValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mLast = N - 1;
    endtask

    // Called at a negedge in IDLE with requests already raised. Acts as the DRAM,
    // answering `lat` cycles after the request is seen, then checks completion.
    task automatic serve(input int lat, input logic [W-1:0] rdata, input bit dropAfter);
        int         e, n;
        logic [1:0] ei;
        logic [W-1:0] eAddr, eData;
        logic       eWr, eRd;
        e = pickNext(rdEn | wrEn, mLast);
        if (e < 0) begin
            chk("noPendingRequest", 64'(0), 64'(1));
            return;
        end
        ei    = e[1:0];
        eAddr = addr[ei];
        eData = wdata[ei];
        eWr   = wrEn[ei];
        eRd   = rdEn[ei] & ~wrEn[ei];
        n = 0;
        while (!(dramReadEnable || dramWriteEnable) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grantTimeout", 64'(n < 20), 64'(1));
        chk("grantLatency", 64'(n), 64'(1));
        chk("grantId", 64'(grantId), 64'(e));
        chk("dramAddress", 64'(dramAddress), 64'(eAddr));
        chk("dramWriteEnable", 64'(dramWriteEnable), 64'(eWr));
        chk("dramReadEnable", 64'(dramReadEnable), 64'(eRd));
        if (eWr) chk("dramWriteData", 64'(dramWriteData), 64'(eData));
        chk("reqValidBusy", 64'(reqValid), 64'(0));
        // Granted requester's inputs change during BUSY and must be ignored.
        addr[ei]  = $urandom;
        wdata[ei] = $urandom;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("holdAddress", 64'(dramAddress), 64'(eAddr));
            chk("holdEnables", 64'({dramWriteEnable, dramReadEnable}), 64'({eWr, eRd}));
            if (eWr) chk("holdWriteData", 64'(dramWriteData), 64'(eData));
        end
        dramReadData = rdata;
        dramValid    = 1'b1;
        @(posedge clk);
        #1;
        dramValid    = 1'b0;
        dramReadData = $urandom;
        @(negedge clk);
        chk("reqValidDone", 64'(reqValid), 64'(4'b0001 << e));
        chk("reqReadData", 64'(reqReadData), 64'(rdata));
        chk("enablesDropped", 64'({dramWriteEnable, dramReadEnable}), 64'(0));
        mLast = e;
        @(posedge clk);
        #1;
        if (dropAfter) begin
            rdEn[ei] = 1'b0;
            wrEn[ei] = 1'b0;
        end
        @(negedge clk);
        chk("reqValidOneCycle", 64'(reqValid), 64'(0));
    endtask

    initial begin
        int order3[3];
        int order4[4];
        int n;
        order3 = '{0, 2, 3};
        order4 = '{0, 1, 0, 1};
        reset = 1'b0;
        rdEn = '0;
        wrEn = '0;
        addr = '0;
        wdata = '0;
        dramValid = 1'b0;
        dramReadData = '0;
        mLast = N - 1;
        #2;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("afterRelease");

        // Single read from requester 1.
        rdEn[1] = 1'b1;
        addr[1] = 32'h40;
        serve(3, 32'h1234, 1'b1);

        // Contention after reset: 0, 2, 3.
        doReset();
        rdEn[0] = 1'b1; addr[0] = 32'h1000;
        wrEn[2] = 1'b1; addr[2] = 32'h2000; wdata[2] = 32'hA5A5_0002;
        rdEn[3] = 1'b1; addr[3] = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            serve(1, 32'h100 + 32'(i), 1'b1);
            chk("contentionOrder", 64'(grantId), 64'(order3[i]));
        end

        // Fairness: requester 0 keeps re-requesting while 1 waits.
        doReset();
        rdEn[0] = 1'b1; addr[0] = 32'h10;
        rdEn[1] = 1'b1; addr[1] = 32'h20;
        for (int i = 0; i < 4; i++) begin
            serve(1, 32'hF000 + 32'(i), i >= 2);
            chk("fairnessOrder", 64'(grantId), 64'(order4[i]));
        end

        // Write from requester 3.
        wrEn[3] = 1'b1; addr[3] = 32'h100; wdata[3] = 32'hDEAD_BEEF;
        serve(4, 32'h0, 1'b1);

        // Read and write together: write wins.
        rdEn[2] = 1'b1; wrEn[2] = 1'b1; addr[2] = 32'h200; wdata[2] = 32'h0BAD_F00D;
        serve(2, 32'h55, 1'b1);

        // Stray dramValid in IDLE.
        dramValid = 1'b1;
        dramReadData = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dramValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("strayReqValid", 64'(reqValid), 64'(0));
            chk("strayEnables", 64'({dramWriteEnable, dramReadEnable}), 64'(0));
        end
        rdEn[1] = 1'b1; addr[1] = 32'h77;
        serve(0, 32'h9999, 1'b1);

        // Reset while requester 2 is busy.
        rdEn[2] = 1'b1; addr[2] = 32'h2222;
        n = 0;
        while (!dramReadEnable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midBusyGrant", 64'(grantId), 64'(2));
        reset = 1'b0;
        #1;
        checkAllZero("midBusyReset");
        dramValid = 1'b1;
        rdEn[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mLast = N - 1;
        @(negedge clk);
        dramValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abandonedNoValid", 64'(reqValid), 64'(0));
            @(negedge clk);
        end
        rdEn[0] = 1'b1; addr[0] = 32'hC0;
        rdEn[2] = 1'b1; addr[2] = 32'hC2;
        serve(1, 32'h0C0C, 1'b1);
        chk("resetFirstGrant", 64'(mLast), 64'(0));
        serve(1, 32'h2C2C, 1'b1);

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N; r++) begin
                if (!(rdEn[r] || wrEn[r]) && $urandom_range(1, 0) == 1) begin
                    int op;
                    op = $urandom_range(2, 0);
                    rdEn[r]  = (op != 1);
                    wrEn[r]  = (op != 0);
                    addr[r]  = $urandom;
                    wdata[r] = $urandom;
                end
            end
            if ((rdEn | wrEn) == '0) begin
                int r;
                r = $urandom_range(N - 1, 0);
                rdEn[r] = 1'b1;
                addr[r] = $urandom;
            end
            serve($urandom_range(3, 0), $urandom, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
